// File: rtl/timer_digit_chain_if.sv
// Control and status bundle of the digit-chain timer.
// master drives controls and reads status; slave is the counter.
interface timer_digit_chain_if #(
    parameter int W = 16
);
    logic         timer_pause;
    logic         timer_clear;
    logic         count_down;
    logic         load_en;
    logic [W-1:0] load_value;
    logic         lap_capture;
    logic [W-1:0] count_value;
    logic [W-1:0] lap_value;
    logic         lap_valid;
    logic         term_pulse;
    logic         at_zero;

    modport master (
        output timer_pause, timer_clear, count_down,
        output load_en, load_value, lap_capture,
        input  count_value, lap_value, lap_valid,
        input  term_pulse, at_zero
    );

    modport slave (
        input  timer_pause, timer_clear, count_down,
        input  load_en, load_value, lap_capture,
        output count_value, lap_value, lap_valid,
        output term_pulse, at_zero
    );
endinterface

// File: rtl/timer_digit_chain.sv
// Mixed-radix cascaded digit counter with tick prescaler,
// up/down count, clamped preset load, lap snapshot, terminal pulse.
module timer_digit_chain #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DIGIT_LIMIT =
        {4'd6, 4'd10, 4'd6, 4'd10},
    parameter int TICK_DIV   = 1,
    parameter bit WRAP_EN    = 1'b1
) (
    input logic           sys_clk,
    input logic           int_reset_b,
    timer_digit_chain_if.slave tmr
);

    localparam int CW = NUM_DIGITS * DIGIT_W;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      lap_q;
    logic [CW-1:0]      step_v, clamp_v;
    logic [PW-1:0]      presc_q, presc_d;
    logic               term_q, term_d;
    logic               lap_v_q;
    logic               all_max, all_zero;
    logic               tick, at_term;
    logic               do_clear, do_load, do_hold, do_run;
    logic [DIGIT_W-1:0] dg, dmax, ld;

    // Per-digit next value for one step, cascade enables, load clamp.
    always_comb begin
        step_v   = '0;
        clamp_v  = '0;
        all_max  = 1'b1;
        all_zero = 1'b1;
        dg       = '0;
        dmax     = '0;
        ld       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dg   = cnt_q[i*DIGIT_W +: DIGIT_W];
            dmax = DIGIT_LIMIT[i*DIGIT_W +: DIGIT_W] - DIGIT_W'(1);
            ld   = tmr.load_value[i*DIGIT_W +: DIGIT_W];
            clamp_v[i*DIGIT_W +: DIGIT_W] = (ld > dmax) ? dmax : ld;
            if (tmr.count_down) begin
                if (all_zero)
                    step_v[i*DIGIT_W +: DIGIT_W] =
                        (dg == '0) ? dmax : dg - DIGIT_W'(1);
                else
                    step_v[i*DIGIT_W +: DIGIT_W] = dg;
            end else begin
                if (all_max)
                    step_v[i*DIGIT_W +: DIGIT_W] =
                        (dg == dmax) ? '0 : dg + DIGIT_W'(1);
                else
                    step_v[i*DIGIT_W +: DIGIT_W] = dg;
            end
            all_max  = all_max & (dg == dmax);
            all_zero = all_zero & (dg == '0);
        end
    end

    assign do_clear = tmr.timer_clear;
    assign do_load  = tmr.load_en & ~tmr.timer_clear;
    assign do_hold  = tmr.timer_pause & ~tmr.load_en & ~tmr.timer_clear;
    assign do_run   = ~(tmr.timer_pause | tmr.load_en | tmr.timer_clear);
    assign tick     = (presc_q == P_LAST);
    assign at_term  = tmr.count_down ? all_zero : all_max;

    // Exclusive command decode: clear, load, pause, then advance.
    always_comb begin
        cnt_d   = cnt_q;
        presc_d = presc_q;
        term_d  = 1'b0;
        unique case (1'b1)
            do_clear: begin
                cnt_d   = '0;
                presc_d = '0;
            end
            do_load: begin
                cnt_d   = clamp_v;
                presc_d = '0;
            end
            do_hold: begin
                cnt_d   = cnt_q;
            end
            do_run: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    term_d = at_term;
                    if (WRAP_EN || !at_term)
                        cnt_d = step_v;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // State registers; lap snapshots the pre-update count.
    always_ff @(posedge sys_clk or negedge int_reset_b) begin
        if (!int_reset_b) begin
            cnt_q   <= '0;
            presc_q <= '0;
            term_q  <= 1'b0;
            lap_q   <= '0;
            lap_v_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            term_q  <= term_d;
            lap_v_q <= tmr.lap_capture;
            if (tmr.lap_capture)
                lap_q <= cnt_q;
        end
    end

    assign tmr.count_value = cnt_q;
    assign tmr.lap_value   = lap_q;
    assign tmr.lap_valid   = lap_v_q;
    assign tmr.term_pulse  = term_q;
    assign tmr.at_zero     = (cnt_q == '0);

endmodule

// File: tb/tb_timer_digit_chain.sv
// Bench for timer_digit_chain: three configurations checked
// every cycle against an integer-seconds reference model.
module tb_timer_digit_chain;

    localparam int TOT = 3600;

    logic        sys_clk     = 1'b0;
    logic        int_reset_b = 1'b0;
    logic        pause = 1'b0, clear = 1'b0, down = 1'b0;
    logic        load  = 1'b0, lap   = 1'b0;
    logic [15:0] lval  = '0;

    always #5 sys_clk = ~sys_clk;

    timer_digit_chain_if #(.W(16)) if0 ();
    timer_digit_chain_if #(.W(16)) if1 ();
    timer_digit_chain_if #(.W(16)) if2 ();

    assign if0.timer_pause = pause;
    assign if0.timer_clear = clear;
    assign if0.count_down  = down;
    assign if0.load_en     = load;
    assign if0.load_value  = lval;
    assign if0.lap_capture = lap;
    assign if1.timer_pause = pause;
    assign if1.timer_clear = clear;
    assign if1.count_down  = down;
    assign if1.load_en     = load;
    assign if1.load_value  = lval;
    assign if1.lap_capture = lap;
    assign if2.timer_pause = pause;
    assign if2.timer_clear = clear;
    assign if2.count_down  = down;
    assign if2.load_en     = load;
    assign if2.load_value  = lval;
    assign if2.lap_capture = lap;

    timer_digit_chain u0 (
        .sys_clk(sys_clk), .int_reset_b(int_reset_b), .tmr(if0)
    );
    timer_digit_chain #(.WRAP_EN(1'b0)) u1 (
        .sys_clk(sys_clk), .int_reset_b(int_reset_b), .tmr(if1)
    );
    timer_digit_chain #(.TICK_DIV(4)) u2 (
        .sys_clk(sys_clk), .int_reset_b(int_reset_b), .tmr(if2)
    );

    logic [15:0] dcnt [3];
    logic [15:0] dlap [3];
    logic        dlv  [3];
    logic        dterm[3];
    logic        dz   [3];

    assign dcnt[0] = if0.count_value;
    assign dcnt[1] = if1.count_value;
    assign dcnt[2] = if2.count_value;
    assign dlap[0] = if0.lap_value;
    assign dlap[1] = if1.lap_value;
    assign dlap[2] = if2.lap_value;
    assign dlv[0]  = if0.lap_valid;
    assign dlv[1]  = if1.lap_valid;
    assign dlv[2]  = if2.lap_valid;
    assign dterm[0] = if0.term_pulse;
    assign dterm[1] = if1.term_pulse;
    assign dterm[2] = if2.term_pulse;
    assign dz[0]   = if0.at_zero;
    assign dz[1]   = if1.at_zero;
    assign dz[2]   = if2.at_zero;

    int tests = 0;
    int fails = 0;
    int u0_terms = 0;
    bit chk_on = 1'b0;

    // Reference state: count as plain seconds in 0..TOT-1.
    int mv[3], mp[3], mlap[3];
    bit mlv[3], mterm[3];
    int tdiv[3] = '{1, 1, 4};
    bit wrp[3]  = '{1'b1, 1'b0, 1'b1};

    function automatic int lim_of(int i);
        return (i % 2 == 0) ? 10 : 6;
    endfunction

    function automatic logic [15:0] to_dig(int v);
        logic [15:0] r = '0;
        int          x = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % lim_of(i));
            x = x / lim_of(i);
        end
        return r;
    endfunction

    function automatic int from_load(logic [15:0] x);
        int v = 0;
        for (int i = 3; i >= 0; i--) begin
            int d;
            d = int'(x[i*4 +: 4]);
            if (d > lim_of(i) - 1) d = lim_of(i) - 1;
            v = v * lim_of(i) + d;
        end
        return v;
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act,
                       logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] t=%0t actual=%h required=%h",
                     nm, k, $time, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    // Reference model update on each clock edge.
    always @(posedge sys_clk or negedge int_reset_b) begin
        for (int k = 0; k < 3; k++) begin
            if (!int_reset_b) begin
                mv[k] <= 0; mp[k] <= 0; mlap[k] <= 0;
                mlv[k] <= 1'b0; mterm[k] <= 1'b0;
            end else begin
                mlv[k]   <= lap;
                if (lap) mlap[k] <= mv[k];
                mterm[k] <= 1'b0;
                if (clear) begin
                    mv[k] <= 0; mp[k] <= 0;
                end else if (load) begin
                    mv[k] <= from_load(lval); mp[k] <= 0;
                end else if (!pause) begin
                    if (mp[k] == tdiv[k] - 1) begin
                        mp[k] <= 0;
                        if (down) begin
                            if (mv[k] == 0) begin
                                mterm[k] <= 1'b1;
                                if (wrp[k]) mv[k] <= TOT - 1;
                            end else mv[k] <= mv[k] - 1;
                        end else begin
                            if (mv[k] == TOT - 1) begin
                                mterm[k] <= 1'b1;
                                if (wrp[k]) mv[k] <= 0;
                            end else mv[k] <= mv[k] + 1;
                        end
                    end else mp[k] <= mp[k] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of all three instances to the model.
    always @(negedge sys_clk) begin
        if (dterm[0]) u0_terms++;
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                chk("count", k, dcnt[k], to_dig(mv[k]));
                chk("lap", k, dlap[k], to_dig(mlap[k]));
                chk("lap_valid", k, dlv[k], mlv[k]);
                chk("term", k, dterm[k], mterm[k]);
                chk("at_zero", k, dz[k], mv[k] == 0);
            end
        end
    end

    initial begin
        #12;
        @(negedge sys_clk);
        #1;
        int_reset_b = 1'b1;
        chk_on = 1'b1;
        chk("rst_count", 0, dcnt[0], 16'h0000);
        chk("rst_zero", 0, dz[0], 1'b1);
        chk("rst_lv", 0, dlv[0], 1'b0);
        chk("rst_term", 0, dterm[0], 1'b0);
        u0_terms = 0;

        step(600);
        chk("up600", 0, dcnt[0], 16'h1000);
        chk("up600_terms", 0, u0_terms, 0);
        chk("up600_div4", 2, dcnt[2], 16'h0230);

        lval = 16'h5959; load = 1'b1;
        step(1);
        load = 1'b0;
        chk("load5959", 0, dcnt[0], 16'h5959);
        step(1);
        chk("wrap_up", 0, dcnt[0], 16'h0000);
        chk("wrap_term", 0, dterm[0], 1'b1);
        chk("sat_up", 1, dcnt[1], 16'h5959);
        chk("sat_term", 1, dterm[1], 1'b1);
        step(1);
        chk("sat_up2", 1, dcnt[1], 16'h5959);
        chk("sat_term2", 1, dterm[1], 1'b1);
        chk("post_wrap", 0, dcnt[0], 16'h0001);
        chk("post_term", 0, dterm[0], 1'b0);

        lval = 16'h0100; down = 1'b1; load = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        chk("down1", 0, dcnt[0], 16'h0059);
        chk("down1_zero", 0, dz[0], 1'b0);
        step(1);
        chk("down2", 0, dcnt[0], 16'h0058);
        step(58);
        chk("down_zero", 0, dcnt[0], 16'h0000);
        chk("down_atz", 0, dz[0], 1'b1);
        step(1);
        chk("wrap_down", 0, dcnt[0], 16'h5959);
        chk("wrap_dterm", 0, dterm[0], 1'b1);
        chk("wrap_datz", 0, dz[0], 1'b0);

        down = 1'b0; clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(2);
        pause = 1'b1;
        step(5);
        pause = 1'b0;
        step(1);
        chk("presc_hold", 2, dcnt[2], 16'h0000);
        step(1);
        chk("presc_adv", 2, dcnt[2], 16'h0001);
        pause = 1'b1; clear = 1'b1;
        step(1);
        chk("clr_pause", 0, dcnt[0], 16'h0000);
        chk("clr_pause", 2, dcnt[2], 16'h0000);
        pause = 1'b0; clear = 1'b0;

        lval = 16'h0A7F; load = 1'b1;
        step(1);
        chk("clamp", 0, dcnt[0], 16'h0959);
        clear = 1'b1;
        step(1);
        chk("load_clr", 0, dcnt[0], 16'h0000);
        load = 1'b0; clear = 1'b0;

        lval = 16'h0123; load = 1'b1;
        step(1);
        load = 1'b0; lap = 1'b1;
        step(1);
        lap = 1'b0;
        chk("lap_val", 0, dlap[0], 16'h0123);
        chk("lap_cnt", 0, dcnt[0], 16'h0124);
        chk("lap_pulse", 0, dlv[0], 1'b1);
        step(1);
        chk("lap_drop", 0, dlv[0], 1'b0);
        chk("lap_keep", 0, dlap[0], 16'h0123);

        repeat (3000) begin
            pause = ($urandom_range(0, 99) < 20);
            clear = ($urandom_range(0, 99) < 2);
            load  = ($urandom_range(0, 99) < 3);
            lap   = ($urandom_range(0, 99) < 10);
            lval  = 16'($urandom);
            if ($urandom_range(0, 99) < 5) down = ~down;
            step(1);
        end

        pause = 1'b0; clear = 1'b0; load = 1'b0;
        lap = 1'b1; down = 1'b0;
        step(7);
        lap = 1'b0;
        @(negedge sys_clk);
        #2;
        int_reset_b = 1'b0;
        #1;
        chk("arst_count", 0, dcnt[0], 16'h0000);
        chk("arst_lap", 0, dlap[0], 16'h0000);
        chk("arst_lv", 0, dlv[0], 1'b0);
        chk("arst_term", 0, dterm[0], 1'b0);
        chk("arst_zero", 0, dz[0], 1'b1);
        step(2);
        int_reset_b = 1'b1;
        step(5);
        chk("post_rst", 0, dcnt[0], 16'h0005);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
